id_ctrl_pipe: RTL and testbench
===============================

Name: id_ctrl_pipe

Overview:
- Parametrised successor to the combinational ARM decode control unit.
- Decodes opcode, mode, S, immediate bit and condition field into control signals.
- Evaluates the condition against NZCV and detects RAW hazards against the EXE and MEM stages.
- Registers the result into the ID/EX control pipeline with stall, flush and bubble insertion. Sits between the IF/ID register and the EXE stage, and drives the IF/ID stall.

Parameters:
EXE_CMD_W, 4, width of ALU command field
REG_ADDR_W, 4, register-file address width
FWD_EN, 0, 1 = forwarding unit present (only load-use hazards stall)
CNT_W, 16, width of saturating bubble counter

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
instr_valid  in  1  IF/ID holds a real instruction
opcode  in  4  instruction opcode field
mode  in  2  00 data-proc, 01 memory, 10 branch, 11 reserved
s_bit  in  1  S bit (L bit in mode 01)
imm  in  1  immediate operand flag
cond  in  4  condition field
status  in  4  NZCV flags {N,Z,C,V}
rn, rm, rd  in  REG_ADDR_W  source/destination fields
exe_wb_en, mem_wb_en  in  1  later-stage writeback enables
exe_mem_r_en  in  1  EXE-stage instruction is a load
exe_dest, mem_dest  in  REG_ADDR_W  later-stage destinations
flush  in  1  branch taken in EXE
hazard  out  1  combinational stall request to PC and IF/ID
ex_valid, ex_s, ex_b, ex_mem_w_en, ex_mem_r_en, ex_wb_en  out  1  registered controls
ex_exe_cmd  out  EXE_CMD_W  registered ALU command
ex_dest  out  REG_ADDR_W  registered destination (rd)
bubble_cnt  out  CNT_W  bubbles inserted since reset, saturating

Behaviour:
- Reset: all ex_* outputs 0, bubble_cnt 0. hazard is combinational, so it is 0 whenever instr_valid is 0.
- Decode (combinational, via sub-module):
  - MOV 1101 → cmd 0001; MVN 1111 → 1001; ADD 0100 (mode 00) → 0010; ADC 0101 → 0011; SUB 0010 → 0100; SBC 0110 → 0101; AND 0000 → 0110; ORR 1100 → 0111; EOR 0001 → 1000. All with wb=1, s=s_bit.
  - CMP 1010 → 0100, TST 1000 → 0110, both with wb=0, s=1.
  - Mode 01 with opcode 0100: s_bit=1 is LDR (cmd 0010, mem_r=1, wb=1, s=0); s_bit=0 is STR (cmd 0010, mem_w=1, wb=0, s=0).
  - Mode 10 is B (b=1, cmd 0000, all enables 0).
  - Any other opcode/mode combination, including mode 11, decodes to NOP: all controls 0, and it does not stall.
- Condition pass: EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1; 1111 0. On fail, the instruction is squashed (bubble) and does not stall.
- Source use:
  - src1 (rn) is used by all except MOV, MVN and B.
  - src2 is used when mode 00 and imm=0 (compared on rm), and for STR (compared on rd).
- Hazard:
  - FWD_EN=0: hazard = instr_valid & cond_pass & ((src match exe_dest & exe_wb_en) | (src match mem_dest & mem_wb_en)).
  - FWD_EN=1: only the EXE term counts, and only when exe_mem_r_en=1.
- Register update each clk edge, priority rst > flush > hazard > load:
  - flush or hazard writes a bubble: ex_valid=0, all ex_* controls 0.
  - load writes the decoded controls, with ex_valid = instr_valid & cond_pass.
- bubble_cnt increments on each edge where a bubble is written while instr_valid=1 (flush, hazard or cond fail). It holds at 2^CNT_W-1.
- flush and hazard in the same cycle: one bubble, counted once.
- Reset mid-stall clears the outputs; hazard re-evaluates from the inputs.
- Latency: 1 cycle from decode inputs to ex_*.

Decomposition:
- Package id_ctrl_pkg: opcode constants, EXE_CMD constants, mode encodings, condition-code constants, and the ctrl bundle typedef {s, b, exe_cmd, mem_w, mem_r, wb}.
- Sub-module ctrl_decode: purely combinational opcode/mode/S to ctrl bundle.
- Condition check, hazard detection and the pipeline register stay in id_ctrl_pipe.

Test Plan:
- Reset: rst=1 for 2 cycles with ADD inputs → all ex_* 0, bubble_cnt 0. Release → next edge ex_exe_cmd=0010, ex_wb_en=1, ex_valid=1.
- Decode sweep: each opcode/mode/s_bit with cond=1110 → the table values. CMP gives ex_s=1, ex_wb_en=0. STR gives ex_mem_w_en=1, ex_wb_en=0. Opcode 0011 in mode 00 gives all 0.
- Condition: BEQ with status=0000 → squash, ex_b=0, bubble_cnt+1. Same with status=0100 → ex_b=1. GT with N=1, V=1, Z=0 → pass.
- Hazard, FWD_EN=0: ADD rn=3 with exe_dest=3, exe_wb_en=1 → hazard=1 and a bubble. With imm=1 and rm=3 as the only match → hazard=0.
- Hazard, FWD_EN=1: same, but exe_mem_r_en=0 → no stall. With exe_mem_r_en=1 → 1-cycle stall.
- Flush with hazard together → single bubble, bubble_cnt+1. With CNT_W=2 and 5 bubbles → bubble_cnt saturates at 3.

Source files
------------

// File: rtl/id_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : id_ctrl_pkg
// Purpose  : Shared encodings and the control bundle for the ID-stage control path.
// Revision : 1.0
// ============================================================================
package id_ctrl_pkg;

   localparam int c_cmd_w = 4;

   // Data-processing opcodes
   localparam logic [3:0] c_op_and = 4'b0000;
   localparam logic [3:0] c_op_eor = 4'b0001;
   localparam logic [3:0] c_op_sub = 4'b0010;
   localparam logic [3:0] c_op_add = 4'b0100;
   localparam logic [3:0] c_op_adc = 4'b0101;
   localparam logic [3:0] c_op_sbc = 4'b0110;
   localparam logic [3:0] c_op_tst = 4'b1000;
   localparam logic [3:0] c_op_cmp = 4'b1010;
   localparam logic [3:0] c_op_orr = 4'b1100;
   localparam logic [3:0] c_op_mov = 4'b1101;
   localparam logic [3:0] c_op_mvn = 4'b1111;
   localparam logic [3:0] c_op_ldst = 4'b0100;

   localparam logic [1:0] c_mode_dp  = 2'b00;
   localparam logic [1:0] c_mode_mem = 2'b01;
   localparam logic [1:0] c_mode_br  = 2'b10;

   localparam logic [c_cmd_w-1:0] c_cmd_nop = 4'b0000;
   localparam logic [c_cmd_w-1:0] c_cmd_mov = 4'b0001;
   localparam logic [c_cmd_w-1:0] c_cmd_add = 4'b0010;
   localparam logic [c_cmd_w-1:0] c_cmd_adc = 4'b0011;
   localparam logic [c_cmd_w-1:0] c_cmd_sub = 4'b0100;
   localparam logic [c_cmd_w-1:0] c_cmd_sbc = 4'b0101;
   localparam logic [c_cmd_w-1:0] c_cmd_and = 4'b0110;
   localparam logic [c_cmd_w-1:0] c_cmd_orr = 4'b0111;
   localparam logic [c_cmd_w-1:0] c_cmd_eor = 4'b1000;
   localparam logic [c_cmd_w-1:0] c_cmd_mvn = 4'b1001;

   localparam logic [3:0] c_cc_eq = 4'd0;
   localparam logic [3:0] c_cc_ne = 4'd1;
   localparam logic [3:0] c_cc_cs = 4'd2;
   localparam logic [3:0] c_cc_cc = 4'd3;
   localparam logic [3:0] c_cc_mi = 4'd4;
   localparam logic [3:0] c_cc_pl = 4'd5;
   localparam logic [3:0] c_cc_vs = 4'd6;
   localparam logic [3:0] c_cc_vc = 4'd7;
   localparam logic [3:0] c_cc_hi = 4'd8;
   localparam logic [3:0] c_cc_ls = 4'd9;
   localparam logic [3:0] c_cc_ge = 4'd10;
   localparam logic [3:0] c_cc_lt = 4'd11;
   localparam logic [3:0] c_cc_gt = 4'd12;
   localparam logic [3:0] c_cc_le = 4'd13;
   localparam logic [3:0] c_cc_al = 4'd14;

   typedef struct packed {
      logic               s;
      logic               b;
      logic [c_cmd_w-1:0] exe_cmd;
      logic               mem_w;
      logic               mem_r;
      logic               wb;
   } ctrl_t;

   localparam ctrl_t c_ctrl_nop = '0;

   // status is {N,Z,C,V}; the 1111 code never passes
   function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] status);
      logic n, z, c, v;
      {n, z, c, v} = status;
      case (cond)
         c_cc_eq: return z;
         c_cc_ne: return ~z;
         c_cc_cs: return c;
         c_cc_cc: return ~c;
         c_cc_mi: return n;
         c_cc_pl: return ~n;
         c_cc_vs: return v;
         c_cc_vc: return ~v;
         c_cc_hi: return c & ~z;
         c_cc_ls: return ~c | z;
         c_cc_ge: return n == v;
         c_cc_lt: return n != v;
         c_cc_gt: return ~z & (n == v);
         c_cc_le: return z | (n != v);
         c_cc_al: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/id_ctrl_pipe_decode.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_decode
// Purpose  : Combinational opcode/mode/S decode into the control bundle and source usage.
// Revision : 1.0
// ============================================================================
module ctrl_decode
   import id_ctrl_pkg::*;
(
   input  logic [3:0] opcode,
   input  logic [1:0] mode,
   input  logic       s_bit,
   input  logic       imm,
   output ctrl_t      ctrl,
   output logic       src1_used,
   output logic       src2_used,
   output logic       src2_is_rd
);

   always_comb begin
      ctrl       = c_ctrl_nop;
      src1_used  = 1'b0;
      src2_used  = 1'b0;
      src2_is_rd = 1'b0;
      case (mode)
         c_mode_dp: begin
            ctrl.wb   = 1'b1;
            ctrl.s    = s_bit;
            src1_used = 1'b1;
            src2_used = ~imm;
            case (opcode)
               c_op_mov: begin ctrl.exe_cmd = c_cmd_mov; src1_used = 1'b0; end
               c_op_mvn: begin ctrl.exe_cmd = c_cmd_mvn; src1_used = 1'b0; end
               c_op_add: ctrl.exe_cmd = c_cmd_add;
               c_op_adc: ctrl.exe_cmd = c_cmd_adc;
               c_op_sub: ctrl.exe_cmd = c_cmd_sub;
               c_op_sbc: ctrl.exe_cmd = c_cmd_sbc;
               c_op_and: ctrl.exe_cmd = c_cmd_and;
               c_op_orr: ctrl.exe_cmd = c_cmd_orr;
               c_op_eor: ctrl.exe_cmd = c_cmd_eor;
               c_op_cmp: begin ctrl.exe_cmd = c_cmd_sub; ctrl.wb = 1'b0; ctrl.s = 1'b1; end
               c_op_tst: begin ctrl.exe_cmd = c_cmd_and; ctrl.wb = 1'b0; ctrl.s = 1'b1; end
               default: begin
                  // Undefined data-processing opcode: a NOP that reads nothing
                  ctrl      = c_ctrl_nop;
                  src1_used = 1'b0;
                  src2_used = 1'b0;
               end
            endcase
         end
         c_mode_mem: begin
            if (opcode == c_op_ldst) begin
               ctrl.exe_cmd = c_cmd_add;
               src1_used    = 1'b1;
               if (s_bit) begin
                  ctrl.mem_r = 1'b1;
                  ctrl.wb    = 1'b1;
               end else begin
                  // Store data comes from rd, so rd is the second source
                  ctrl.mem_w = 1'b1;
                  src2_used  = 1'b1;
                  src2_is_rd = 1'b1;
               end
            end
         end
         c_mode_br: ctrl.b = 1'b1;
         default: ctrl = c_ctrl_nop;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/id_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module   : id_ctrl_pipe
// Purpose  : ID-stage decode, condition check, RAW hazard detection and ID/EX control register.
// Revision : 1.0
// ============================================================================
module id_ctrl_pipe
   import id_ctrl_pkg::*;
#(
   parameter int EXE_CMD_W  = 4,
   parameter int REG_ADDR_W = 4,
   parameter int FWD_EN     = 0,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  instr_valid,
   input  logic [3:0]            opcode,
   input  logic [1:0]            mode,
   input  logic                  s_bit,
   input  logic                  imm,
   input  logic [3:0]            cond,
   input  logic [3:0]            status,
   input  logic [REG_ADDR_W-1:0] rn,
   input  logic [REG_ADDR_W-1:0] rm,
   input  logic [REG_ADDR_W-1:0] rd,
   input  logic                  exe_wb_en,
   input  logic                  mem_wb_en,
   input  logic                  exe_mem_r_en,
   input  logic [REG_ADDR_W-1:0] exe_dest,
   input  logic [REG_ADDR_W-1:0] mem_dest,
   input  logic                  flush,
   output logic                  hazard,
   output logic                  ex_valid,
   output logic                  ex_s,
   output logic                  ex_b,
   output logic                  ex_mem_w_en,
   output logic                  ex_mem_r_en,
   output logic                  ex_wb_en,
   output logic [EXE_CMD_W-1:0]  ex_exe_cmd,
   output logic [REG_ADDR_W-1:0] ex_dest,
   output logic [CNT_W-1:0]      bubble_cnt
);

   localparam logic c_fwd = (FWD_EN != 0);

   ctrl_t                 w_ctrl;
   logic                  w_src1_used;
   logic                  w_src2_used;
   logic                  w_src2_is_rd;
   logic                  w_cond_pass;
   logic [REG_ADDR_W-1:0] w_src2_addr;
   logic                  w_hit_exe;
   logic                  w_hit_mem;
   logic                  w_raw;
   logic                  w_issue;
   logic                  w_bubble;
   logic                  w_count;

   ctrl_t                 r_ctrl;
   logic                  r_valid;
   logic [REG_ADDR_W-1:0] r_dest;
   logic [CNT_W-1:0]      r_cnt;

   ctrl_decode u_decode (
      .opcode     (opcode),
      .mode       (mode),
      .s_bit      (s_bit),
      .imm        (imm),
      .ctrl       (w_ctrl),
      .src1_used  (w_src1_used),
      .src2_used  (w_src2_used),
      .src2_is_rd (w_src2_is_rd)
   );

   assign w_cond_pass = cond_pass(cond, status);
   assign w_src2_addr = w_src2_is_rd ? rd : rm;

   assign w_hit_exe = exe_wb_en & ((w_src1_used & (rn == exe_dest)) |
                                   (w_src2_used & (w_src2_addr == exe_dest)));
   assign w_hit_mem = mem_wb_en & ((w_src1_used & (rn == mem_dest)) |
                                   (w_src2_used & (w_src2_addr == mem_dest)));

   // With forwarding only a load in EXE cannot be bypassed in time
   assign w_raw  = (w_hit_exe & (exe_mem_r_en | ~c_fwd)) | (w_hit_mem & ~c_fwd);
   assign hazard = instr_valid & w_cond_pass & w_raw;

   assign w_issue  = instr_valid & w_cond_pass;
   assign w_bubble = flush | hazard | ~w_issue;
   assign w_count  = instr_valid & (flush | hazard | ~w_cond_pass);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ctrl  <= c_ctrl_nop;
         r_valid <= 1'b0;
         r_dest  <= '0;
         r_cnt   <= '0;
      end else begin
         if (w_bubble) begin
            r_ctrl  <= c_ctrl_nop;
            r_valid <= 1'b0;
            r_dest  <= '0;
         end else begin
            r_ctrl  <= w_ctrl;
            r_valid <= 1'b1;
            r_dest  <= rd;
         end
         if (w_count && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign ex_valid    = r_valid;
   assign ex_s        = r_ctrl.s;
   assign ex_b        = r_ctrl.b;
   assign ex_mem_w_en = r_ctrl.mem_w;
   assign ex_mem_r_en = r_ctrl.mem_r;
   assign ex_wb_en    = r_ctrl.wb;
   assign ex_exe_cmd  = EXE_CMD_W'(r_ctrl.exe_cmd);
   assign ex_dest     = r_dest;
   assign bubble_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ctrl_pipe
// Purpose  : Directed and randomized check of id_ctrl_pipe (no-forwarding and forwarding builds).
// Revision : 1.0
// ============================================================================
module tb_id_ctrl_pipe;

   logic       clk = 1'b0;
   logic       rst, instr_valid, s_bit, imm, flush;
   logic       exe_wb_en, mem_wb_en, exe_mem_r_en;
   logic [3:0] opcode, cond, status, rn, rm, rd, exe_dest, mem_dest;
   logic [1:0] mode;

   logic       hazard0, v0, s0, b0, mw0, mr0, wb0;
   logic [3:0] cmd0, dest0;
   logic [15:0] cnt0;
   logic       hazard1, v1, s1, b1, mw1, mr1, wb1;
   logic [3:0] cmd1, dest1;
   logic [1:0] cnt1;

   int checks = 0;
   int errors = 0;
   bit run_cmp = 1'b0;

   always #5 clk = ~clk;

   id_ctrl_pipe #(.EXE_CMD_W(4), .REG_ADDR_W(4), .FWD_EN(0), .CNT_W(16)) dut0 (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode), .mode(mode),
      .s_bit(s_bit), .imm(imm), .cond(cond), .status(status), .rn(rn), .rm(rm), .rd(rd),
      .exe_wb_en(exe_wb_en), .mem_wb_en(mem_wb_en), .exe_mem_r_en(exe_mem_r_en),
      .exe_dest(exe_dest), .mem_dest(mem_dest), .flush(flush), .hazard(hazard0),
      .ex_valid(v0), .ex_s(s0), .ex_b(b0), .ex_mem_w_en(mw0), .ex_mem_r_en(mr0),
      .ex_wb_en(wb0), .ex_exe_cmd(cmd0), .ex_dest(dest0), .bubble_cnt(cnt0)
   );

   id_ctrl_pipe #(.EXE_CMD_W(4), .REG_ADDR_W(4), .FWD_EN(1), .CNT_W(2)) dut1 (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode), .mode(mode),
      .s_bit(s_bit), .imm(imm), .cond(cond), .status(status), .rn(rn), .rm(rm), .rd(rd),
      .exe_wb_en(exe_wb_en), .mem_wb_en(mem_wb_en), .exe_mem_r_en(exe_mem_r_en),
      .exe_dest(exe_dest), .mem_dest(mem_dest), .flush(flush), .hazard(hazard1),
      .ex_valid(v1), .ex_s(s1), .ex_b(b1), .ex_mem_w_en(mw1), .ex_mem_r_en(mr1),
      .ex_wb_en(wb1), .ex_exe_cmd(cmd1), .ex_dest(dest1), .bubble_cnt(cnt1)
   );

   // ---------------- reference model ----------------
   typedef struct packed {
      logic s, b, mw, mr, wb, u1, u2, u2rd;
      logic [3:0] cmd;
   } dec_t;

   typedef struct packed {
      logic valid, s, b, mw, mr, wb;
      logic [3:0] cmd, dest;
   } exo_t;

   // ALU command per data-processing opcode, -1 marks an undefined opcode
   int dp_cmd [16] = '{6, 8, 4, -1, 2, 3, 5, -1, 6, -1, 4, -1, 7, 1, -1, 9};
   int cnt_max [2] = '{65535, 3};
   exo_t exp_o [2];
   int   exp_cnt [2];

   function automatic dec_t ref_dec();
      dec_t d = '0;
      if (mode == 2'b10) begin
         d.b = 1'b1;
      end else if (mode == 2'b01 && opcode == 4'd4) begin
         d.cmd = 4'd2;
         d.u1  = 1'b1;
         if (s_bit) begin d.mr = 1'b1; d.wb = 1'b1; end
         else begin d.mw = 1'b1; d.u2 = 1'b1; d.u2rd = 1'b1; end
      end else if (mode == 2'b00 && dp_cmd[opcode] >= 0) begin
         d.cmd = 4'(dp_cmd[opcode]);
         d.wb  = !(opcode == 4'd8 || opcode == 4'd10);
         d.s   = (opcode == 4'd8 || opcode == 4'd10) ? 1'b1 : s_bit;
         d.u1  = !(opcode == 4'd13 || opcode == 4'd15);
         d.u2  = !imm;
      end
      return d;
   endfunction

   function automatic bit ref_cond();
      bit n = status[3], z = status[2], c = status[1], v = status[0];
      bit base;
      if (cond == 4'd15) return 1'b0;
      case (cond[3:1])
         3'd0: base = z;
         3'd1: base = c;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = c && !z;
         3'd5: base = (n == v);
         3'd6: base = !z && (n == v);
         default: base = 1'b1;
      endcase
      return cond[0] ? !base : base;
   endfunction

   function automatic bit ref_hazard(bit fwd);
      dec_t d = ref_dec();
      logic [3:0] s2 = d.u2rd ? rd : rm;
      bit m_exe = exe_wb_en && ((d.u1 && rn == exe_dest) || (d.u2 && s2 == exe_dest));
      bit m_mem = mem_wb_en && ((d.u1 && rn == mem_dest) || (d.u2 && s2 == mem_dest));
      if (!(instr_valid && ref_cond())) return 1'b0;
      return fwd ? (m_exe && exe_mem_r_en) : (m_exe || m_mem);
   endfunction

   function automatic exo_t next_o(bit fwd);
      dec_t d = ref_dec();
      exo_t o = '0;
      if (!flush && !ref_hazard(fwd) && instr_valid && ref_cond()) begin
         o.valid = 1'b1; o.s = d.s; o.b = d.b; o.mw = d.mw; o.mr = d.mr;
         o.wb = d.wb; o.cmd = d.cmd; o.dest = rd;
      end
      return o;
   endfunction

   function automatic int next_cnt(int cur, int mx, bit fwd);
      bit bub = instr_valid && (flush || ref_hazard(fwd) || !ref_cond());
      return (bub && cur < mx) ? cur + 1 : cur;
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            exp_o[i]   <= '0;
            exp_cnt[i] <= 0;
         end else begin
            exp_o[i]   <= next_o(i == 1);
            exp_cnt[i] <= next_cnt(exp_cnt[i], cnt_max[i], i == 1);
         end
      end
   end

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (run_cmp) begin
         cmp("hazard0", 32'(hazard0), 32'(ref_hazard(1'b0)));
         cmp("ex_out0", 32'({v0, s0, b0, mw0, mr0, wb0, cmd0, dest0}), 32'(exp_o[0]));
         cmp("bubble_cnt0", 32'(cnt0), 32'(exp_cnt[0]));
         cmp("hazard1", 32'(hazard1), 32'(ref_hazard(1'b1)));
         cmp("ex_out1", 32'({v1, s1, b1, mw1, mr1, wb1, cmd1, dest1}), 32'(exp_o[1]));
         cmp("bubble_cnt1", 32'(cnt1), 32'(exp_cnt[1]));
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(input logic [1:0] md, input logic [3:0] op, input logic sb,
                            input logic im, input logic [3:0] cc);
      mode = md; opcode = op; s_bit = sb; imm = im; cond = cc;
   endtask

   int c_prev;

   initial begin
      rst = 1'b1; instr_valid = 1'b1; flush = 1'b0; status = 4'd0;
      rn = 4'd1; rm = 4'd0; rd = 4'd2;
      exe_wb_en = 1'b0; mem_wb_en = 1'b0; exe_mem_r_en = 1'b0;
      exe_dest = 4'd0; mem_dest = 4'd0;
      set_instr(2'b00, 4'b0100, 1'b0, 1'b1, 4'b1110);
      step();
      run_cmp = 1'b1;
      step();
      cmp("rst_valid", 32'(v0), 32'd0);
      cmp("rst_wb", 32'(wb0), 32'd0);
      cmp("rst_cnt", 32'(cnt0), 32'd0);
      rst = 1'b0;
      step();
      cmp("add_cmd", 32'(cmd0), 32'h2);
      cmp("add_wb", 32'(wb0), 32'd1);
      cmp("add_valid", 32'(v0), 32'd1);

      set_instr(2'b00, 4'b1010, 1'b0, 1'b1, 4'b1110);
      step();
      cmp("cmp_s", 32'(s0), 32'd1);
      cmp("cmp_wb", 32'(wb0), 32'd0);
      cmp("cmp_cmd", 32'(cmd0), 32'h4);

      set_instr(2'b01, 4'b0100, 1'b0, 1'b1, 4'b1110);
      step();
      cmp("str_mem_w", 32'(mw0), 32'd1);
      cmp("str_wb", 32'(wb0), 32'd0);

      set_instr(2'b00, 4'b0011, 1'b1, 1'b0, 4'b1110);
      step();
      cmp("undef_ctrl", 32'({s0, b0, mw0, mr0, wb0, cmd0}), 32'd0);

      set_instr(2'b10, 4'b0000, 1'b0, 1'b0, 4'b0000);
      c_prev = int'(cnt0);
      step();
      cmp("beq_fail_b", 32'(b0), 32'd0);
      cmp("beq_fail_cnt", 32'(cnt0), 32'(c_prev + 1));
      status = 4'b0100;
      step();
      cmp("beq_pass_b", 32'(b0), 32'd1);

      set_instr(2'b00, 4'b0100, 1'b0, 1'b1, 4'b1100);
      status = 4'b1001;
      step();
      cmp("gt_pass", 32'(v0), 32'd1);

      status = 4'd0; cond = 4'b1110;
      rn = 4'd3; rm = 4'd0; exe_dest = 4'd3; exe_wb_en = 1'b1; exe_mem_r_en = 1'b0;
      #1;
      cmp("raw_hazard0", 32'(hazard0), 32'd1);
      cmp("raw_nofwd1", 32'(hazard1), 32'd0);
      c_prev = int'(cnt0);
      step();
      cmp("raw_bubble0", 32'(v0), 32'd0);
      cmp("raw_cnt0", 32'(cnt0), 32'(c_prev + 1));
      cmp("raw_pass1", 32'(v1), 32'd1);

      rn = 4'd5; rm = 4'd3;
      #1;
      cmp("imm_rm_nohaz", 32'(hazard0), 32'd0);
      step();

      rn = 4'd3; exe_mem_r_en = 1'b1;
      #1;
      cmp("load_use1", 32'(hazard1), 32'd1);
      step();
      cmp("load_use_bub1", 32'(v1), 32'd0);

      flush = 1'b1;
      c_prev = int'(cnt0);
      step();
      cmp("flush_haz_cnt", 32'(cnt0), 32'(c_prev + 1));
      repeat (5) step();
      cmp("cnt_saturate", 32'(cnt1), 32'd3);
      flush = 1'b0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
      step();

      repeat (3000) begin
         rst          = ($urandom_range(0, 99) < 2);
         instr_valid  = ($urandom_range(0, 99) < 85);
         flush        = ($urandom_range(0, 99) < 10);
         mode         = 2'($urandom_range(0, 3));
         opcode       = 4'($urandom);
         s_bit        = 1'($urandom);
         imm          = 1'($urandom);
         cond         = ($urandom_range(0, 1) == 0) ? 4'b1110 : 4'($urandom);
         status       = 4'($urandom);
         rn           = 4'($urandom_range(0, 3));
         rm           = 4'($urandom_range(0, 3));
         rd           = 4'($urandom_range(0, 3));
         exe_dest     = 4'($urandom_range(0, 3));
         mem_dest     = 4'($urandom_range(0, 3));
         exe_wb_en    = 1'($urandom);
         mem_wb_en    = 1'($urandom);
         exe_mem_r_en = 1'($urandom);
         step();
      end

      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
